// File: rtl/gray_binary_rx.sv
`default_nettype none
// gray_binary_rx: registered Gray-to-binary decoder with valid/ready handshakes,
// single-step adjacency check, count direction and saturating error count. Rev 1.0
module gray_binary_rx #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 dir_up,
    output logic                 repeat_o,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_err
);
    localparam logic [WIDTH-1:0]     C_BIN_ONE = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = ERR_CNT_W'(1);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 dir_q, dir_d;
    logic                 rep_q, rep_d;
    logic                 step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 have_prev_q, have_prev_d;
    logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;

    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             diff_zero;
    logic             diff_one;
    logic             err_det;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Prefix XOR from the MSB down yields the binary value.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        decoded = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc        = acc ^ gray_in[i];
            decoded[i] = acc;
        end
    end

    // A single differing bit is a nonzero power of two.
    assign diff      = gray_in ^ prev_gray_q;
    assign diff_zero = (diff == '0);
    assign diff_one  = !diff_zero && ((diff & (diff - C_BIN_ONE)) == '0);
    assign err_det   = accept && have_prev_q && !diff_zero && !diff_one;

    always_comb begin
        out_valid_d = out_valid_q;
        bin_d       = bin_q;
        dir_d       = dir_q;
        rep_d       = rep_q;
        step_err_d  = step_err_q;
        err_cnt_d   = err_cnt_q;
        have_prev_d = have_prev_q;
        prev_gray_d = prev_gray_q;
        prev_bin_d  = prev_bin_q;

        if (accept) begin
            out_valid_d = 1'b1;
            bin_d       = decoded;
            dir_d       = have_prev_q && diff_one && (decoded == prev_bin_q + C_BIN_ONE);
            rep_d       = have_prev_q && diff_zero;
            have_prev_d = 1'b1;
            prev_gray_d = gray_in;
            prev_bin_d  = decoded;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A detected error takes priority over a coincident clear.
        if (err_det) begin
            step_err_d = 1'b1;
            if (clear_err) begin
                err_cnt_d = C_CNT_ONE;
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + C_CNT_ONE;
            end
        end else if (clear_err) begin
            step_err_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            dir_q       <= 1'b0;
            rep_q       <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            have_prev_q <= 1'b0;
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bin_q       <= bin_d;
            dir_q       <= dir_d;
            rep_q       <= rep_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
            have_prev_q <= have_prev_d;
            prev_gray_q <= prev_gray_d;
            prev_bin_q  <= prev_bin_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign dir_up    = dir_q;
    assign repeat_o  = rep_q;
    assign step_err  = step_err_q;
    assign err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/gray_binary_rx.md
# gray_binary_rx

Registered Gray-to-binary decoder with valid/ready handshakes on both sides. It is the receive end of the team's binary-to-Gray encode path, e.g. for pointers or counters that cross a domain boundary in Gray code. Besides decoding, it checks that successive accepted codes differ by at most one bit and reports the count direction. It flags and counts illegal multi-bit steps.

## Interface
Parameters:
- WIDTH, 4, code width in bits (legal range 2..16).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  gray_in is presented.
- in_ready  output  1  block accepts gray_in this cycle.
- gray_in  input  WIDTH  Gray-coded input word.
- out_valid  output  1  bin_out and status are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- bin_out  output  WIDTH  decoded binary word.
- dir_up  output  1  accepted word is binary previous+1 (mod 2^WIDTH); 0 for −1, repeat, first word or error.
- repeat_o  output  1  accepted word equals the previous accepted word.
- step_err  output  1  sticky flag: some accepted word differed from its predecessor in 2 or more bits.
- err_count  output  ERR_CNT_W  number of illegal steps, saturating at all-ones.
- clear_err  input  1  synchronous clear of step_err and err_count.

## Operation
- Decode rule: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Accept: a word is accepted when in_valid && in_ready.
- Ready: in_ready = !out_valid || out_ready. It is combinational from out_ready.
- Output stage: a single register stage holds bin_out, dir_up and repeat_o.
  - out_valid sets on accept.
  - out_valid clears on out_ready when there is no new accept in the same cycle.
  - A simultaneous drain and accept reloads the register; no bubble is inserted.
- Adjacency check: d = popcount(gray_in ^ prev_gray). It is evaluated only on accept, and only when have_prev = 1.
  - d = 0: repeat_o = 1, dir_up = 0.
  - d = 1: dir_up = 1 if decoded value == prev_bin + 1 mod 2^WIDTH, else 0. Wrap from all-ones to 0 counts as up.
  - d ≥ 2: step_err ← 1; err_count increments, saturating; dir_up = 0, repeat_o = 0.
- History: on every accept, prev_gray ← gray_in, prev_bin ← decoded value, have_prev ← 1.
  - The first word after reset only sets the history: no error, dir_up = 0, repeat_o = 0.
- clear_err: clears step_err and err_count next cycle.
  - If an error is detected in the same cycle, the error wins: step_err = 1 and err_count = 1.
- Output stability: while out_valid && !out_ready, all outputs hold stable and in_ready = 0.

## Timing
- Latency: 1 cycle from accept to out_valid/bin_out.
- Throughput: 1 word/cycle while out_ready = 1.
- Reset values: out_valid 0, bin_out 0, dir_up 0, repeat_o 0, step_err 0, err_count 0. Internally, have_prev 0, prev_gray 0, prev_bin 0.
- in_ready reads 1 during and immediately after reset.
- Reset mid-transfer: an asynchronous assert drops out_valid immediately and discards the held word and the history. The next accepted word is treated as the first.
- Status updates (step_err, err_count) take effect on the same edge that loads the output register.

## Test plan
- Decode sweep, WIDTH = 4, out_ready = 1: feed Gray 0..15 in count order (0000, 0001, 0011, ..., 1000) → bin_out 0..15, each one cycle after its accept.
  - dir_up = 1 for all words except the first.
  - step_err = 0.
  - Spot checks: 0110 → 0100; 1000 → 1111.
- Wrap and down count: feed 1000 (15), 0000 (0), 1000 (15).
  - The second word gives dir_up = 1.
  - The third word gives dir_up = 0 with no error.
- Illegal step: feed 0000, then 0011 → step_err = 1, err_count = 1, dir_up = 0. Then assert clear_err for one cycle → step_err = 0, err_count = 0.
  - Clear/error collision: assert clear_err in the same cycle as a 2-bit step → step_err = 1, err_count = 1.
- Repeat and saturation:
  - Feed 0101 twice → the second word gives repeat_o = 1 with no error.
  - With ERR_CNT_W = 2, feed 5 illegal steps → err_count = 3, holding.
- Backpressure: hold out_ready = 0 after accepting 0001.
  - in_ready = 0 and bin_out = 0001 stay stable for 5 cycles.
  - Raise out_ready while presenting 0011 → back-to-back transfer: 0010 appears next cycle.
- Async reset: assert rst_n = 0 mid-stream while out_valid = 1.
  - All outputs go to their reset values without a clock edge.
  - After release, the first word (e.g. 1111) raises no error.
